// File: rtl/matrix_mem_sequencer.sv
// Command sequencer in front of the 256-bit x 16 matrix RAM.
// For each command it reads operands A and B, issues them to the matrix
// execution unit, collects the result and writes it back to RAM.
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | CmdReady high, RAM idle, waiting for CmdValid
// RD_A     | RAM read of SrcA
// RD_B     | RAM read of SrcB, capture A from DataOut at exit edge
// CAP_B    | RAM idle, capture B from DataOut at exit edge
// ISSUE    | OpValid high until the execution unit takes the operands
// WAIT_RES | ResReady high until a result arrives
// WRITE    | RAM write of the result to Dst
// DONE     | one-cycle Done pulse, DoneCount advanced
module matrix_mem_sequencer #(
   parameter int DATA_W = 256,
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic              CmdValid,
   output logic              CmdReady,
   input  logic [ADDR_W-1:0] CmdSrcA,
   input  logic [ADDR_W-1:0] CmdSrcB,
   input  logic [ADDR_W-1:0] CmdDst,
   output logic              MemEnable,
   output logic              MemReadWrite,
   output logic [ADDR_W-1:0] MemAddress,
   output logic [DATA_W-1:0] MemDataIn,
   input  logic [DATA_W-1:0] MemDataOut,
   output logic              OpValid,
   input  logic              OpReady,
   output logic [DATA_W-1:0] OpA,
   output logic [DATA_W-1:0] OpB,
   input  logic              ResValid,
   output logic              ResReady,
   input  logic [DATA_W-1:0] ResData,
   output logic              Done,
   output logic [CNT_W-1:0]  DoneCount
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_A, S_RD_B, S_CAP_B, S_ISSUE, S_WAIT_RES, S_WRITE, S_DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] src_b_q;
   logic [ADDR_W-1:0] dst_q;

   // Command acceptance is decoded from the state register alone.
   assign CmdReady = (state == S_IDLE);

   // Sequencer FSM; every RAM and handshake output is set on the edge
   // that enters the state in which it must be visible.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state        <= S_IDLE;
         src_b_q      <= '0;
         dst_q        <= '0;
         MemEnable    <= 1'b0;
         MemReadWrite <= 1'b1;
         MemAddress   <= '0;
         MemDataIn    <= '0;
         OpA          <= '0;
         OpB          <= '0;
         OpValid      <= 1'b0;
         ResReady     <= 1'b0;
         Done         <= 1'b0;
         DoneCount    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (CmdValid) begin
                  src_b_q      <= CmdSrcB;
                  dst_q        <= CmdDst;
                  MemEnable    <= 1'b1;
                  MemReadWrite <= 1'b1;
                  MemAddress   <= CmdSrcA;
                  state        <= S_RD_A;
               end
            end
            S_RD_A: begin
               MemAddress <= src_b_q;
               state      <= S_RD_B;
            end
            S_RD_B: begin
               // DataOut now carries word A from the RD_A edge.
               OpA        <= MemDataOut;
               MemEnable  <= 1'b0;
               MemAddress <= '0;
               state      <= S_CAP_B;
            end
            S_CAP_B: begin
               OpB     <= MemDataOut;
               OpValid <= 1'b1;
               state   <= S_ISSUE;
            end
            S_ISSUE: begin
               if (OpReady) begin
                  OpValid  <= 1'b0;
                  ResReady <= 1'b1;
                  state    <= S_WAIT_RES;
               end
            end
            S_WAIT_RES: begin
               if (ResValid) begin
                  MemDataIn    <= ResData;
                  ResReady     <= 1'b0;
                  MemEnable    <= 1'b1;
                  MemReadWrite <= 1'b0;
                  MemAddress   <= dst_q;
                  state        <= S_WRITE;
               end
            end
            S_WRITE: begin
               MemEnable    <= 1'b0;
               MemReadWrite <= 1'b1;
               MemAddress   <= '0;
               Done         <= 1'b1;
               DoneCount    <= DoneCount + 1'b1;
               state        <= S_DONE;
            end
            S_DONE: begin
               Done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_mem_sequencer.sv
// Bench for matrix_mem_sequencer: behavioural RAM and execution unit,
// a table of directed commands plus hand-written reset and wrap sequences.
module tb_matrix_mem_sequencer;

   localparam int DATA_W = 256;
   localparam int ADDR_W = 4;
   localparam int CNT_W  = 8;

   logic              Clock;
   logic              nReset;
   logic              CmdValid;
   logic              CmdReady;
   logic [ADDR_W-1:0] CmdSrcA, CmdSrcB, CmdDst;
   logic              MemEnable, MemReadWrite;
   logic [ADDR_W-1:0] MemAddress;
   logic [DATA_W-1:0] MemDataIn, MemDataOut;
   logic              OpValid, OpReady;
   logic [DATA_W-1:0] OpA, OpB;
   logic              ResValid, ResReady;
   logic [DATA_W-1:0] ResData;
   logic              Done;
   logic [CNT_W-1:0]  DoneCount;

   matrix_mem_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .Clock(Clock), .nReset(nReset),
      .CmdValid(CmdValid), .CmdReady(CmdReady),
      .CmdSrcA(CmdSrcA), .CmdSrcB(CmdSrcB), .CmdDst(CmdDst),
      .MemEnable(MemEnable), .MemReadWrite(MemReadWrite),
      .MemAddress(MemAddress), .MemDataIn(MemDataIn), .MemDataOut(MemDataOut),
      .OpValid(OpValid), .OpReady(OpReady), .OpA(OpA), .OpB(OpB),
      .ResValid(ResValid), .ResReady(ResReady), .ResData(ResData),
      .Done(Done), .DoneCount(DoneCount)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // RAM model: DataOut is valid only in the cycle after a read edge.
   logic [DATA_W-1:0] ram [16];
   logic [DATA_W-1:0] ram_dout;
   logic              ram_dv;
   int                write_count;

   always @(posedge Clock) begin
      if (MemEnable && MemReadWrite) begin
         ram_dout <= ram[MemAddress];
         ram_dv   <= 1'b1;
      end else begin
         ram_dv <= 1'b0;
         if (MemEnable) begin
            ram[MemAddress] <= MemDataIn;
            write_count     <= write_count + 1;
         end
      end
   end
   assign MemDataOut = ram_dv ? ram_dout : '0;

   localparam logic [DATA_W-1:0] RAM0 =
      256'h0004_000c_0008_0010_0002_0007_0009_000b_0005_0006_000a_000e_0001_000f_000d_0003;
   localparam logic [DATA_W-1:0] RAM1 =
      256'h0017_002d_0011_0020_0030_0040_0050_0060_0070_0080_0090_00a0_00b0_00c0_00d0_0013;
   localparam logic [DATA_W-1:0] SUM01 =
      256'h001b_0039_0019_0030_0032_0047_0059_006b_0075_0086_009a_00ae_00b1_00cf_00dd_0016;

   typedef struct {
      logic [3:0]        srca, srcb, dst;
      int                op;         // 0: A+B, 1: A+1 per element
      int                op_stall;   // cycles OpReady is held low in ISSUE
      int                res_delay;  // cycles ResValid is held low in WAIT_RES
      bit                mid_cmd;    // pulse CmdValid during WAIT_RES
      bit                use_lit;
      logic [DATA_W-1:0] lit;
   } cmd_t;

   logic [DATA_W-1:0] shadow [16];
   logic [CNT_W-1:0]  exp_cnt;
   int                checks;
   int                errors;

   function automatic cmd_t mk(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                               input int op, input int st, input int rd, input bit mid,
                               input bit ul, input logic [DATA_W-1:0] lit);
      cmd_t c;
      c.srca = a; c.srcb = b; c.dst = d; c.op = op; c.op_stall = st;
      c.res_delay = rd; c.mid_cmd = mid; c.use_lit = ul; c.lit = lit;
      return c;
   endfunction

   function automatic logic [DATA_W-1:0] exec_model(input int op, input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] r;
      for (int k = 0; k < 16; k++)
         r[k*16 +: 16] = (op == 1) ? a[k*16 +: 16] + 16'd1 : a[k*16 +: 16] + b[k*16 +: 16];
      return r;
   endfunction

   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic run_cmd(input cmd_t c);
      logic [DATA_W-1:0] ea, eb, er;
      int wc0, cyc, opv_cycles, rr_cycles, issue_n, wait_n, done_cyc;
      bit done_seen;
      ea = shadow[c.srca];
      eb = shadow[c.srcb];
      er = exec_model(c.op, ea, eb);
      opv_cycles = 0; rr_cycles = 0; issue_n = 0; wait_n = 0;
      done_seen = 1'b0; done_cyc = 0;
      @(negedge Clock);
      check("cmd_ready_idle", 256'(CmdReady), 256'd1);
      CmdValid = 1'b1;
      CmdSrcA  = c.srca; CmdSrcB = c.srcb; CmdDst = c.dst;
      OpReady  = (c.op_stall == 0);
      ResValid = (c.res_delay == 0);
      ResData  = er;
      wc0 = write_count;
      @(posedge Clock);
      @(negedge Clock);
      cyc = 1;
      while (!done_seen && cyc < 80) begin
         CmdValid = 1'b0;
         if (OpValid) begin
            opv_cycles++;
            check("op_a", OpA, ea);
            check("op_b", OpB, eb);
            OpReady = (issue_n >= c.op_stall);
            issue_n++;
         end else begin
            OpReady = (c.op_stall == 0);
         end
         if (ResReady) begin
            rr_cycles++;
            if (wait_n >= c.res_delay) ResValid = 1'b1;
            if (c.mid_cmd && wait_n == 0) begin
               CmdValid = 1'b1;
               CmdSrcA = 4'hf; CmdSrcB = 4'hf; CmdDst = 4'hf;
            end
            wait_n++;
         end
         if (Done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
            check("write_before_done", 256'(write_count - wc0), 256'd1);
         end else begin
            @(negedge Clock);
            cyc++;
         end
      end
      CmdValid = 1'b0; OpReady = 1'b0; ResValid = 1'b0;
      exp_cnt = exp_cnt + 1'b1;
      check("done_seen", 256'(done_seen), 256'd1);
      check("done_latency", 256'(done_cyc), 256'(7 + c.op_stall + c.res_delay));
      check("opvalid_cycles", 256'(opv_cycles), 256'(c.op_stall + 1));
      check("resready_cycles", 256'(rr_cycles), 256'(c.res_delay + 1));
      check("ram_dst", ram[c.dst], er);
      if (c.use_lit) check("ram_dst_literal", ram[c.dst], c.lit);
      check("done_count", 256'(DoneCount), 256'(exp_cnt));
      shadow[c.dst] = er;
      @(negedge Clock);
      check("done_one_cycle", 256'(Done), 256'd0);
      check("back_to_idle", 256'(CmdReady), 256'd1);
      check("single_write", 256'(write_count - wc0), 256'd1);
   endtask

   cmd_t vec [5];

   initial begin
      logic [DATA_W-1:0] w;
      int wc0;
      bit seen;
      checks = 0; errors = 0; exp_cnt = '0;
      write_count = 0; ram_dv = 1'b0; ram_dout = '0;
      nReset = 1'b1; CmdValid = 1'b0; CmdSrcA = '0; CmdSrcB = '0; CmdDst = '0;
      OpReady = 1'b0; ResValid = 1'b0; ResData = '0;

      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < 16; k++) w[k*16 +: 16] = 16'(i * 256 + k + 1);
         if (i == 0) w = RAM0;
         if (i == 1) w = RAM1;
         if (i == 7) w = '0;
         ram[i] <= w;
         shadow[i] = w;
      end

      vec[0] = mk(4'd0, 4'd1, 4'd5, 0, 0, 0, 1'b0, 1'b1, SUM01);
      vec[1] = mk(4'd3, 4'd4, 4'd6, 0, 3, 4, 1'b0, 1'b0, '0);
      vec[2] = mk(4'd5, 4'd8, 4'd9, 0, 2, 0, 1'b0, 1'b0, '0);
      vec[3] = mk(4'd2, 4'd2, 4'd2, 1, 0, 0, 1'b0, 1'b0, '0);
      vec[4] = mk(4'd10, 4'd11, 4'd12, 0, 1, 2, 1'b1, 1'b0, '0);

      // Asynchronous reset asserted between clock edges.
      @(posedge Clock);
      @(posedge Clock);
      #3 nReset = 1'b0;
      #1;
      check("rst_cmd_ready", 256'(CmdReady), 256'd1);
      check("rst_mem_enable", 256'(MemEnable), 256'd0);
      check("rst_op_valid", 256'(OpValid), 256'd0);
      check("rst_done_count", 256'(DoneCount), 256'd0);
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      nReset = 1'b1;

      for (int i = 0; i < 5; i++) run_cmd(vec[i]);

      // Reset while operands are being offered: no write to RAM[7].
      @(negedge Clock);
      wc0 = write_count;
      CmdValid = 1'b1; CmdSrcA = 4'd3; CmdSrcB = 4'd4; CmdDst = 4'd7;
      OpReady = 1'b0; ResValid = 1'b1; ResData = {DATA_W{1'b1}};
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge Clock);
         CmdValid = 1'b0;
         seen = OpValid;
      end
      check("reach_issue", 256'(seen), 256'd1);
      #2 nReset = 1'b0;
      #1;
      check("midrst_idle", 256'(CmdReady), 256'd1);
      check("midrst_op_valid", 256'(OpValid), 256'd0);
      check("midrst_mem_enable", 256'(MemEnable), 256'd0);
      check("midrst_done_count", 256'(DoneCount), 256'd0);
      exp_cnt = '0;
      ResValid = 1'b0;
      repeat (2) @(negedge Clock);
      nReset = 1'b1;
      repeat (4) @(negedge Clock);
      check("midrst_ram7", ram[7], '0);
      check("midrst_no_write", 256'(write_count - wc0), 256'd0);

      // Counter wrap: 256 completed commands after the reset.
      for (int i = 0; i < 256; i++) begin
         run_cmd(mk(4'(i), 4'(i + 3), 4'(i + 5), 0, 0, 0, (i == 100), 1'b0, '0));
         if (i == 254) check("count_ff", 256'(DoneCount), 256'h0ff);
      end
      check("count_wrap", 256'(DoneCount), 256'h000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/matrix_mem_sequencer.md
Name: matrix_mem_sequencer

Overview:
- Command sequencer that sits directly in front of the 256-bit x 16-deep matrix RAM.
- Each matrix is a 4x4 array of 16-bit elements packed into one 256-bit word.
- Per command it:
  - reads operand matrices A and B from RAM;
  - hands them to the matrix execution unit over a valid/ready handshake;
  - collects the 256-bit result;
  - writes the result back to a destination RAM word.
- It is the sole master of the RAM's Enable, ReadWrite, Address and DataIn pins, and the sole consumer of its DataOut bus.

Parameters:
- DATA_W, 256, matrix word width (16 elements x 16 bits).
- ADDR_W, 4, RAM address width (16 words).
- CNT_W, 8, width of the completed-command counter.

Ports:
- Clock  in  1  system clock; all state changes on posedge.
- nReset  in  1  asynchronous active-low reset.
- CmdValid  in  1  command request.
- CmdReady  out  1  high only in IDLE; a command is accepted when CmdValid & CmdReady at a posedge.
- CmdSrcA  in  ADDR_W  RAM address of operand A.
- CmdSrcB  in  ADDR_W  RAM address of operand B.
- CmdDst  in  ADDR_W  RAM address for the result.
- MemEnable  out  1  to RAM Enable.
- MemReadWrite  out  1  to RAM ReadWrite (1 = read, 0 = write).
- MemAddress  out  ADDR_W  to RAM Address.
- MemDataIn  out  DATA_W  to RAM DataIn.
- MemDataOut  in  DATA_W  from RAM DataOut; valid the cycle after a read edge, Z otherwise.
- OpValid  out  1  operands valid to execution unit.
- OpReady  in  1  execution unit accepts operands.
- OpA  out  DATA_W  registered operand A.
- OpB  out  DATA_W  registered operand B.
- ResValid  in  1  execution unit result valid.
- ResReady  out  1  sequencer accepts result.
- ResData  in  DATA_W  result matrix.
- Done  out  1  one-cycle pulse when write-back completes.
- DoneCount  out  CNT_W  number of completed commands, wraps modulo 2^CNT_W.

Behaviour:
- Reset (nReset low, asynchronous, any state):
  - state = IDLE; MemEnable = 0; MemReadWrite = 1; MemAddress = 0.
  - MemDataIn, OpA, OpB = 0; OpValid, ResReady, Done = 0; DoneCount = 0.
  - Latched command addresses cleared.
  - A reset mid-operation aborts the command with no RAM write.
- All outputs are registered or decoded from the state register only; no input-to-output combinational paths.
- RAM timing contract: RAM samples Enable/ReadWrite/Address at posedge. On a read, DataOut updates at that same edge, so the sequencer samples MemDataOut at the following posedge.
- FSM, one state per cycle unless noted:
  - IDLE:
    - CmdReady = 1; all Mem outputs idle (Enable 0).
    - On CmdValid, latch SrcA/SrcB/Dst and go to RD_A.
  - RD_A: MemEnable = 1, MemReadWrite = 1, MemAddress = SrcA. Next RD_B.
  - RD_B: MemEnable = 1, MemReadWrite = 1, MemAddress = SrcB. At the exit edge, OpA <= MemDataOut. Next CAP_B.
  - CAP_B: MemEnable = 0. At the exit edge, OpB <= MemDataOut. Next ISSUE.
  - ISSUE:
    - OpValid = 1; OpA and OpB held stable.
    - Stay until OpReady is sampled high, then go to WAIT_RES.
    - OpValid drops on the next cycle.
  - WAIT_RES:
    - ResReady = 1.
    - On ResValid, latch ResData into MemDataIn and go to WRITE.
    - A ResValid asserted during ISSUE is not consumed; the producer must hold it.
  - WRITE: MemEnable = 1, MemReadWrite = 0, MemAddress = Dst, MemDataIn = latched result. Next DONE.
  - DONE:
    - Done = 1 for exactly one cycle; DoneCount increments (FF wraps to 00).
    - Return to IDLE.
- Minimum command latency: accept edge to Done pulse is 7 cycles when OpReady and ResValid are already high.
- Back-to-back commands: the next command is accepted no earlier than the cycle after DONE, because CmdReady is high only in IDLE.
- CmdValid outside IDLE is ignored; no queuing.
- SrcA == SrcB: two reads are still performed; OpA == OpB.
- Dst equal to SrcA or SrcB is legal; the write happens after both reads, so the source is overwritten only after use.
- MemEnable = 0 in every state except RD_A, RD_B and WRITE.

Test Plan:
- Reset then idle:
  - Drive nReset low mid-cycle, then release.
  - Required: CmdReady = 1, MemEnable = 0, OpValid = 0, DoneCount = 0, with no clock edge needed for the outputs to clear.
- Basic command:
  - Preload RAM[0] = 0004_000c_…_0003 and RAM[1] = 0017_002d_…_0013. Issue CmdSrcA = 0, CmdSrcB = 1, CmdDst = 5. Hold OpReady = 1; return ResValid = 1 with ResData = elementwise sum.
  - Required: OpA = RAM[0] and OpB = RAM[1] when OpValid rises; RAM[5] = sum; Done pulses 7 cycles after accept; DoneCount = 1.
- Handshake stalls:
  - Hold OpReady = 0 for 3 cycles, then assert ResValid 4 cycles after operand acceptance.
  - Required: OpValid held with stable OpA/OpB; ResReady held; exactly one RAM write; no Done before the write.
- In-place and aliased operands:
  - Issue SrcA = SrcB = Dst = 2 with result = operand + 1.
  - Required: OpA == OpB == old RAM[2]; RAM[2] updated afterwards.
- Reset mid-operation:
  - Assert nReset during ISSUE with Dst = 7 and RAM[7] = 0.
  - Required: RAM[7] unchanged; state IDLE; a subsequent command completes normally.
- Counter wrap and ignored command:
  - Run 256 commands; pulse CmdValid during WAIT_RES.
  - Required: DoneCount returns to 00; the mid-flight CmdValid causes no extra command.
